// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Summary  : Shared signal encodings and detector FSM state type for the
//            traffic-light controller slice.
// Revision : 1.0
// ============================================================================
package traffic_pkg;

    typedef logic [2:0] signal_t;

    localparam signal_t RED    = 3'd0;
    localparam signal_t YELLOW = 3'd1;
    localparam signal_t GREEN  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT    = 2'b01,
        ST_SERVE   = 2'b10,
        ST_BACKOFF = 2'b11
    } det_state_t;

endpackage
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sensor_debounce
// Summary  : Two-flop synchronizer plus level debouncer for the loop sensor.
// Revision : 1.0
// ============================================================================
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic CLOCK,
    input  logic CLEAR,
    input  logic SENSOR_RAW,
    output logic CAR_PRESENT
);

    localparam int c_dcnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_dcnt_w-1:0] c_dcnt_last = c_dcnt_w'(DEBOUNCE_CYCLES - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic [c_dcnt_w-1:0] r_dcnt;

    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_dcnt      <= '0;
            CAR_PRESENT <= 1'b0;
        end else begin
            r_sync1 <= SENSOR_RAW;
            r_sync2 <= r_sync1;
            // Any agreement restarts the hold window, so only an unbroken run counts.
            if (r_sync2 == CAR_PRESENT) begin
                r_dcnt <= '0;
            end else if (r_dcnt == c_dcnt_last) begin
                CAR_PRESENT <= r_sync2;
                r_dcnt      <= '0;
            end else begin
                r_dcnt <= r_dcnt + c_dcnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cntry_car_detector.sv
`default_nettype none
// ============================================================================
// Module   : cntry_car_detector
// Summary  : Turns the raw country-road loop sensor into CAR_ON_CNTRY_RD.
//            Define CAR_DET_STATS_EN to enable the saturating CAR_COUNT.
// Revision : 1.0
// ============================================================================
module cntry_car_detector
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int MAX_GREEN       = 16
) (
    input  logic       CLOCK,
    input  logic       CLEAR,
    input  logic       SENSOR_RAW,
    input  logic [2:0] MAIN_SIG,
    input  logic [2:0] CNTRY_SIG,
    output logic       CAR_ON_CNTRY_RD,
    output logic       CAR_PRESENT,
    output logic [7:0] CAR_COUNT
);

    localparam int c_gcnt_w = $clog2(MAX_GREEN + 1);
    localparam logic [c_gcnt_w-1:0] c_gcnt_last = c_gcnt_w'(MAX_GREEN - 1);

    det_state_t          r_state;
    det_state_t          w_next;
    logic [c_gcnt_w-1:0] r_gcnt;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLOCK      (CLOCK),
        .CLEAR      (CLEAR),
        .SENSOR_RAW (SENSOR_RAW),
        .CAR_PRESENT(CAR_PRESENT)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (CAR_PRESENT) w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (CNTRY_SIG == GREEN) w_next = ST_SERVE;
            end
            ST_SERVE: begin
                // A departed car outranks the green-time limit.
                if (!CAR_PRESENT)                w_next = ST_IDLE;
                else if (r_gcnt == c_gcnt_last)  w_next = ST_BACKOFF;
                else if (CNTRY_SIG != GREEN)     w_next = ST_WAIT;
            end
            ST_BACKOFF: begin
                if ((CNTRY_SIG == RED) && (MAIN_SIG == GREEN)) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            r_state         <= ST_IDLE;
            r_gcnt          <= '0;
            CAR_ON_CNTRY_RD <= 1'b0;
        end else begin
            r_state         <= w_next;
            CAR_ON_CNTRY_RD <= (w_next == ST_WAIT) || (w_next == ST_SERVE);
            if ((w_next == ST_SERVE) && (r_state != ST_SERVE)) begin
                r_gcnt <= '0;
            end else if (r_state == ST_SERVE) begin
                r_gcnt <= r_gcnt + c_gcnt_w'(1);
            end
        end
    end

`ifdef CAR_DET_STATS_EN
    logic [7:0] r_count;

    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            r_count <= 8'd0;
        end else if ((r_state == ST_IDLE) && (w_next == ST_WAIT) && (r_count != 8'd255)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign CAR_COUNT = r_count;
`else
    assign CAR_COUNT = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cntry_car_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_cntry_car_detector
// Summary  : Scoreboard bench for cntry_car_detector at default parameters.
// Revision : 1.0
// ============================================================================
module tb_cntry_car_detector;
    import traffic_pkg::*;

    localparam int DC = 3;
    localparam int MG = 16;
`ifdef CAR_DET_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       CLOCK = 1'b0;
    logic       CLEAR;
    logic       SENSOR_RAW;
    logic [2:0] MAIN_SIG;
    logic [2:0] CNTRY_SIG;
    logic       CAR_ON_CNTRY_RD;
    logic       CAR_PRESENT;
    logic [7:0] CAR_COUNT;

    typedef struct {
        string      tag;
        logic [2:0] mask;   // bit0 request, bit1 present, bit2 count
        logic       on;
        logic       pres;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    cntry_car_detector #(
        .DEBOUNCE_CYCLES(DC),
        .MAX_GREEN      (MG)
    ) dut (
        .CLOCK          (CLOCK),
        .CLEAR          (CLEAR),
        .SENSOR_RAW     (SENSOR_RAW),
        .MAIN_SIG       (MAIN_SIG),
        .CNTRY_SIG      (CNTRY_SIG),
        .CAR_ON_CNTRY_RD(CAR_ON_CNTRY_RD),
        .CAR_PRESENT    (CAR_PRESENT),
        .CAR_COUNT      (CAR_COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic exp_t mk(string tag, logic [2:0] mask, logic on, logic pres, logic [7:0] cnt);
        exp_t x;
        x.tag  = tag;
        x.mask = mask;
        x.on   = on;
        x.pres = pres;
        x.cnt  = cnt;
        return x;
    endfunction

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_clear();
        CLEAR      = 1'b1;
        SENSOR_RAW = 1'b0;
        CNTRY_SIG  = RED;
        MAIN_SIG   = GREEN;
        repeat (2) step();
        CLEAR = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        CLEAR      = 1'b1;
        SENSOR_RAW = 1'b1;
        CNTRY_SIG  = RED;
        MAIN_SIG   = GREEN;
        for (int k = 1; k <= 12; k++) begin
            if (k == 6) CLEAR = 1'b0;
            if (k <= 5) sb.push_back(mk("reset_hold", 3'b111, 1'b0, 1'b0, 8'd0));
            else        sb.push_back(mk("reset_release", 3'b111, (k - 5) >= 6, (k - 5) >= 5,
                                        (STATS && (k - 5) >= 6) ? 8'd1 : 8'd0));
            step();
            e = sb.pop_front();
            if (e.mask[0]) begin
                n_cmp++;
                if (CAR_ON_CNTRY_RD !== e.on) begin n_bad++; $display("FAIL %s k=%0d request got %b expected %b", e.tag, k, CAR_ON_CNTRY_RD, e.on); end
            end
            if (e.mask[1]) begin
                n_cmp++;
                if (CAR_PRESENT !== e.pres) begin n_bad++; $display("FAIL %s k=%0d present got %b expected %b", e.tag, k, CAR_PRESENT, e.pres); end
            end
            if (e.mask[2]) begin
                n_cmp++;
                if (CAR_COUNT !== e.cnt) begin n_bad++; $display("FAIL %s k=%0d count got %0d expected %0d", e.tag, k, CAR_COUNT, e.cnt); end
            end
        end
    endtask

    task automatic test_latched();
        exp_t e;
        do_clear();
        for (int k = 1; k <= 22; k++) begin
            SENSOR_RAW = (k <= 10);
            CNTRY_SIG  = (k >= 19) ? GREEN : RED;
            sb.push_back(mk("latched", 3'b011, (k >= 6) && (k <= 19), (k >= 5) && (k < 15), 8'd0));
            step();
            e = sb.pop_front();
            if (e.mask[0]) begin
                n_cmp++;
                if (CAR_ON_CNTRY_RD !== e.on) begin n_bad++; $display("FAIL %s k=%0d request got %b expected %b", e.tag, k, CAR_ON_CNTRY_RD, e.on); end
            end
            if (e.mask[1]) begin
                n_cmp++;
                if (CAR_PRESENT !== e.pres) begin n_bad++; $display("FAIL %s k=%0d present got %b expected %b", e.tag, k, CAR_PRESENT, e.pres); end
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        do_clear();
        for (int k = 1; k <= 12; k++) begin
            SENSOR_RAW = (k <= 2);
            sb.push_back(mk("glitch", 3'b011, 1'b0, 1'b0, 8'd0));
            step();
            e = sb.pop_front();
            if (e.mask[0]) begin
                n_cmp++;
                if (CAR_ON_CNTRY_RD !== e.on) begin n_bad++; $display("FAIL %s k=%0d request got %b expected %b", e.tag, k, CAR_ON_CNTRY_RD, e.on); end
            end
            if (e.mask[1]) begin
                n_cmp++;
                if (CAR_PRESENT !== e.pres) begin n_bad++; $display("FAIL %s k=%0d present got %b expected %b", e.tag, k, CAR_PRESENT, e.pres); end
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        do_clear();
        SENSOR_RAW = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            CNTRY_SIG = (k >= 31) ? RED : GREEN;
            MAIN_SIG  = (k >= 31) ? GREEN : RED;
            // SERVE is entered on edge 7, so the 16th SERVE cycle ends on edge 23.
            sb.push_back(mk("timeout", 3'b011, ((k >= 6) && (k <= 22)) || (k >= 32), k >= 5, 8'd0));
            step();
            e = sb.pop_front();
            if (e.mask[0]) begin
                n_cmp++;
                if (CAR_ON_CNTRY_RD !== e.on) begin n_bad++; $display("FAIL %s k=%0d request got %b expected %b", e.tag, k, CAR_ON_CNTRY_RD, e.on); end
            end
            if (e.mask[1]) begin
                n_cmp++;
                if (CAR_PRESENT !== e.pres) begin n_bad++; $display("FAIL %s k=%0d present got %b expected %b", e.tag, k, CAR_PRESENT, e.pres); end
            end
        end
    endtask

    task automatic test_clear_mid_serve();
        exp_t e;
        do_clear();
        for (int k = 1; k <= 21; k++) begin
            CLEAR      = (k == 9);
            SENSOR_RAW = (k <= 9) || (k >= 15);
            CNTRY_SIG  = (k <= 9) ? GREEN : RED;
            MAIN_SIG   = RED;
            if (k <= 8)       sb.push_back(mk("clr_pre", 3'b011, k >= 6, k >= 5, 8'd0));
            else if (k == 9)  sb.push_back(mk("clr_edge", 3'b111, 1'b0, 1'b0, 8'd0));
            else              sb.push_back(mk("clr_idle", 3'b011, k >= 20, k >= 19, 8'd0));
            step();
            e = sb.pop_front();
            if (e.mask[0]) begin
                n_cmp++;
                if (CAR_ON_CNTRY_RD !== e.on) begin n_bad++; $display("FAIL %s k=%0d request got %b expected %b", e.tag, k, CAR_ON_CNTRY_RD, e.on); end
            end
            if (e.mask[1]) begin
                n_cmp++;
                if (CAR_PRESENT !== e.pres) begin n_bad++; $display("FAIL %s k=%0d present got %b expected %b", e.tag, k, CAR_PRESENT, e.pres); end
            end
            if (e.mask[2]) begin
                n_cmp++;
                if (CAR_COUNT !== e.cnt) begin n_bad++; $display("FAIL %s k=%0d count got %0d expected %0d", e.tag, k, CAR_COUNT, e.cnt); end
            end
        end
        CLEAR = 1'b0;
    endtask

    task automatic test_simultaneous();
        exp_t e;
        do_clear();
        for (int k = 1; k <= 14; k++) begin
            SENSOR_RAW = (k <= 6);
            CNTRY_SIG  = (k >= 11) ? GREEN : RED;
            sb.push_back(mk("simul", 3'b011, (k >= 6) && (k <= 11), (k >= 5) && (k < 11), 8'd0));
            step();
            e = sb.pop_front();
            if (e.mask[0]) begin
                n_cmp++;
                if (CAR_ON_CNTRY_RD !== e.on) begin n_bad++; $display("FAIL %s k=%0d request got %b expected %b", e.tag, k, CAR_ON_CNTRY_RD, e.on); end
            end
            if (e.mask[1]) begin
                n_cmp++;
                if (CAR_PRESENT !== e.pres) begin n_bad++; $display("FAIL %s k=%0d present got %b expected %b", e.tag, k, CAR_PRESENT, e.pres); end
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        do_clear();
        for (int k = 1; k <= 30; k++) begin
            SENSOR_RAW = (k <= 17) || (k >= 24);
            CNTRY_SIG  = (k >= 24) ? RED : GREEN;
            MAIN_SIG   = RED;
            // Presence drops on edge 22; edge 23 sees the drop and the timeout together.
            sb.push_back(mk("priority", 3'b011, ((k >= 6) && (k <= 22)) || (k >= 29),
                            ((k >= 5) && (k < 22)) || (k >= 28), 8'd0));
            step();
            e = sb.pop_front();
            if (e.mask[0]) begin
                n_cmp++;
                if (CAR_ON_CNTRY_RD !== e.on) begin n_bad++; $display("FAIL %s k=%0d request got %b expected %b", e.tag, k, CAR_ON_CNTRY_RD, e.on); end
            end
            if (e.mask[1]) begin
                n_cmp++;
                if (CAR_PRESENT !== e.pres) begin n_bad++; $display("FAIL %s k=%0d present got %b expected %b", e.tag, k, CAR_PRESENT, e.pres); end
            end
        end
    endtask

    task automatic test_stats();
        exp_t e;
        int   want;
        do_clear();
        CNTRY_SIG = GREEN;
        MAIN_SIG  = RED;
        for (int j = 0; j < 300 * 12; j++) begin
            int k;
            k          = (j % 12) + 1;
            SENSOR_RAW = (k <= 6);
            want       = (j / 12) + 1;
            if (want > 255) want = 255;
            if (!STATS) want = 0;
            if (k == 6 || k == 12) begin
                sb.push_back(mk((k == 6) ? "stats_rise" : "stats_fall", 3'b101, k == 6, 1'b0, 8'(want)));
            end
            step();
            if (k == 6 || k == 12) begin
                e = sb.pop_front();
                if (e.mask[0]) begin
                    n_cmp++;
                    if (CAR_ON_CNTRY_RD !== e.on) begin n_bad++; $display("FAIL %s j=%0d request got %b expected %b", e.tag, j, CAR_ON_CNTRY_RD, e.on); end
                end
                if (e.mask[2]) begin
                    n_cmp++;
                    if (CAR_COUNT !== e.cnt) begin n_bad++; $display("FAIL %s j=%0d count got %0d expected %0d", e.tag, j, CAR_COUNT, e.cnt); end
                end
            end
        end
    endtask

    initial begin
        CLEAR      = 1'b1;
        SENSOR_RAW = 1'b0;
        MAIN_SIG   = GREEN;
        CNTRY_SIG  = RED;
        test_reset();
        test_latched();
        test_glitch();
        test_timeout();
        test_clear_mid_serve();
        test_simultaneous();
        test_priority();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
